lm_scan_engine: RTL and testbench

LM_SCAN_ENGINE -- requirements
Module: lm_scan_engine

---
 rtl/lm_pkg.sv | 43 ++++
 rtl/lm_scan_engine_if.sv | 40 ++++
 rtl/lm_bcm_timer.sv | 34 +++
 rtl/lm_scan_engine.sv | 146 ++++++++++++++
 tb/tb_lm_scan_engine.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lm_pkg.sv
// Shared types and constant helpers for the LED-matrix scan engine.
package lm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_WAIT,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK
  } lm_state_t;

  function automatic int lm_clog2(input logic [63:0] v);
    int r;
    logic [63:0] x;
    r = 0;
    x = 64'd1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Vector width for a count of n items; never narrower than one bit.
  function automatic int lm_width(input int n);
    int r;
    r = lm_clog2(64'(unsigned'(n)));
    return (r < 1) ? 1 : r;
  endfunction

  // Width that holds the longest display time, BCM_BASE << (PLANES-1).
  function automatic int lm_timer_width(input int base, input int planes);
    logic [63:0] m;
    int r;
    m = 64'(unsigned'(base));
    m = m << (planes - 1);
    r = lm_clog2(m + 64'd1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lm_scan_engine_if.sv
// Panel-side bundle of the scan engine: tick qualifier, run request, pixel
// address toward the frame store, and the HUB75-style panel controls.
interface lm_scan_engine_if #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 8
);
  import lm_pkg::*;

  localparam int COL_W   = lm_width(COLS);
  localparam int PLANE_W = lm_width(PLANES);

  // No valid/ready pair here: clk_enable qualifies every edge, enable is a
  // level request, and every output is a register updated only on ticks.
  logic                clk_enable;
  logic                enable;
  logic [COL_W-1:0]    pix_column;
  logic [ROW_BITS-1:0] pix_row;
  logic [PLANE_W-1:0]  pix_plane;
  logic [ROW_BITS-1:0] matrix_addr;
  logic                matrix_clk;
  logic                matrix_lat;
  logic                matrix_OE;
  logic                frame_done;
  logic                busy;
  lm_state_t           dbg_state;

  modport master (
    output clk_enable, enable,
    input  pix_column, pix_row, pix_plane, matrix_addr, matrix_clk,
    input  matrix_lat, matrix_OE, frame_done, busy, dbg_state
  );

  modport slave (
    input  clk_enable, enable,
    output pix_column, pix_row, pix_plane, matrix_addr, matrix_clk,
    output matrix_lat, matrix_OE, frame_done, busy, dbg_state
  );

endinterface

// File: rtl/lm_bcm_timer.sv
// Display-time countdown for binary code modulation; zero is registered so
// the panel output enable comes straight off a flop.
module lm_bcm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] r_count;
  logic         r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (tick) begin
      if (load) begin
        r_count <= load_value;
        r_zero  <= (load_value == '0);
      end else if (!r_zero) begin
        r_count <= r_count - W'(1);
        r_zero  <= (r_count == W'(1));
      end
    end
  end

  assign zero = r_zero;

endmodule

// File: rtl/lm_scan_engine.sv
// Row/plane scan sequencer for an LED matrix: shifts one row of one
// bit-plane, blanks, latches, then shows it for BCM_BASE << plane ticks.
module lm_scan_engine
  import lm_pkg::*;
#(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 8,
  parameter int BCM_BASE = 1,
  parameter int BLANK    = 2
) (
  input logic           clk,
  input logic           rst,
  lm_scan_engine_if.slave bus
);

  localparam int COL_W   = lm_width(COLS);
  localparam int PLANE_W = lm_width(PLANES);
  localparam int TMR_W   = lm_timer_width(BCM_BASE, PLANES);
  localparam int BLK_W   = lm_width(BLANK);

  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = {ROW_BITS{1'b1}};
  localparam logic [BLK_W-1:0]    BLK_LAST   = BLK_W'(BLANK - 1);

  lm_state_t           r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_BITS-1:0] r_row;
  logic [PLANE_W-1:0]  r_plane;
  logic [ROW_BITS-1:0] r_addr;
  logic [BLK_W-1:0]    r_blank_cnt;
  logic                r_mclk;
  logic                r_lat;
  logic                r_frame_done;
  logic                r_busy;

  logic                w_tick;
  logic                w_load;
  logic [TMR_W-1:0]    w_load_value;
  logic                w_zero;

  assign w_tick       = bus.clk_enable;
  assign w_load       = (r_state == ST_LATCH);
  assign w_load_value = TMR_W'(BCM_BASE) << r_plane;

  // Loaded on the latch tick so the count is live during UNBLANK; OE follows zero.
  lm_bcm_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_value (w_load_value),
    .tick       (w_tick),
    .zero       (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_addr       <= '0;
      r_blank_cnt  <= '0;
      r_mclk       <= 1'b0;
      r_lat        <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_tick) begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_state <= ST_SHIFT_LO;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          r_state <= ST_SHIFT_HI;
          r_mclk  <= 1'b1;
        end
        ST_SHIFT_HI: begin
          r_mclk <= 1'b0;
          if (r_col == COL_LAST) begin
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_SHIFT_LO;
            r_col   <= r_col + COL_W'(1);
          end
        end
        ST_WAIT: begin
          if (w_zero) begin
            r_state     <= ST_BLANK;
            r_blank_cnt <= '0;
          end
        end
        ST_BLANK: begin
          if (r_blank_cnt == BLK_LAST) begin
            r_state      <= ST_LATCH;
            r_lat        <= 1'b1;
            r_addr       <= r_row;
            r_frame_done <= (r_row == ROW_LAST) && (r_plane == PLANE_LAST);
          end else begin
            r_blank_cnt <= r_blank_cnt + BLK_W'(1);
          end
        end
        ST_LATCH: begin
          r_state <= ST_UNBLANK;
          r_lat   <= 1'b0;
        end
        ST_UNBLANK: begin
          r_col <= '0;
          if (r_plane == PLANE_LAST) begin
            r_plane <= '0;
            r_row   <= r_row + ROW_BITS'(1);
          end else begin
            r_plane <= r_plane + PLANE_W'(1);
          end
          if (bus.enable) begin
            r_state <= ST_SHIFT_LO;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_column  = r_col;
  assign bus.pix_row     = r_row;
  assign bus.pix_plane   = r_plane;
  assign bus.matrix_addr = r_addr;
  assign bus.matrix_clk  = r_mclk;
  assign bus.matrix_lat  = r_lat;
  assign bus.matrix_OE   = w_zero;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = r_busy;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_lm_scan_engine.sv
// Bench for lm_scan_engine: a phase-level model of the scan sequence feeds an
// expected queue that is checked against the DUT on every clock.
module tb_lm_scan_engine;
  import lm_pkg::*;

  localparam int COLS     = 4;
  localparam int ROW_BITS = 1;
  localparam int PLANES   = 2;
  localparam int BCM_BASE = 4;
  localparam int BLANK    = 2;
  localparam int ROWS     = 2;

  typedef struct packed {
    logic       cv;
    logic [1:0] col;
    logic       row;
    logic       plane;
    logic       addr;
    logic       mclk;
    logic       lat;
    logic       oe;
    logic       fd;
    logic       busy;
  } vec_t;
  localparam int EW = $bits(vec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lm_scan_engine_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES)) bus ();

  lm_scan_engine #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES),
    .BCM_BASE(BCM_BASE), .BLANK(BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int   m_row, m_plane, m_addr, m_disp;
  bit   chk_on = 1'b0;
  bit   c_tick, c_on;
  vec_t prev, act, cmp, e;
  int   lat_log[$];
  int   oe_runs[$];
  int   fd_count, fd_idx, oe_run, clk_hi;

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic vec_t dut_vec();
    vec_t v;
    v.cv    = 1'b1;
    v.col   = bus.pix_column;
    v.row   = bus.pix_row;
    v.plane = bus.pix_plane;
    v.addr  = bus.matrix_addr;
    v.mclk  = bus.matrix_clk;
    v.lat   = bus.matrix_lat;
    v.oe    = bus.matrix_OE;
    v.fd    = bus.frame_done;
    v.busy  = bus.busy;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // m_disp = ticks of panel light still owed; the panel is dark when it is 0.
  task automatic model_reset();
    exp_q.delete();
    m_row = 0; m_plane = 0; m_addr = 0; m_disp = 0;
  endtask

  task automatic emit(input bit cv, input int col, input bit mclk, input bit lat,
                      input bit fd, input bit busy);
    vec_t v;
    v.cv    = cv;
    v.col   = cv ? 2'(col) : 2'd0;
    v.row   = 1'(m_row);
    v.plane = 1'(m_plane);
    v.addr  = 1'(m_addr);
    v.mclk  = mclk;
    v.lat   = lat;
    v.oe    = (m_disp == 0);
    v.fd    = fd;
    v.busy  = busy;
    if (m_disp > 0) m_disp--;
    exp_q.push_back(v);
  endtask

  task automatic gen_pass();
    bit z;
    for (int c = 0; c < COLS; c++) begin
      emit(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b1);
      emit(1'b1, c, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    do begin
      z = (m_disp == 0);
      emit(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end while (!z);
    repeat (BLANK) emit(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_addr = m_row;
    emit(1'b0, 0, 1'b0, 1'b1, (m_row == ROWS-1) && (m_plane == PLANES-1), 1'b1);
    m_disp = BCM_BASE << m_plane;
    emit(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_plane++;
    if (m_plane == PLANES) begin
      m_plane = 0;
      m_row   = (m_row + 1) % ROWS;
    end
  endtask

  task automatic gen_idle(input int n);
    repeat (n) emit(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    c_tick = bus.clk_enable;
    c_on   = chk_on;
    #1;
    if (c_on) begin
      act = dut_vec();
      if (c_tick) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_underflow", 1, 0);
        end else begin
          e = vec_t'(exp_q.pop_front());
          cmp = act;
          cmp.cv = e.cv;
          if (!e.cv) cmp.col = 2'd0;
          n_tests++;
          if (cmp !== e) begin
            n_fail++;
            $display("FAIL tick_outputs @%0t: got %b, want %b (cv col row plane addr clk lat oe fd busy)",
                     $time, cmp, e);
          end
        end
        if (act.lat) lat_log.push_back(int'(act.row) * 2 + int'(act.plane));
        if (act.fd) begin
          fd_count++;
          fd_idx = lat_log.size() - 1;
        end
        if (act.mclk) clk_hi++;
        if (!act.oe) oe_run++;
        else if (oe_run > 0) begin
          oe_runs.push_back(oe_run);
          oe_run = 0;
        end
      end else begin
        n_tests++;
        if (act !== prev) begin
          n_fail++;
          $display("FAIL hold_on_disabled @%0t: got %b, want %b", $time, act, prev);
        end
      end
      prev = act;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clk_enable = 1'b0;
    repeat (2) @(negedge clk);
    if (check_vals) begin
      check("rst_oe",    bus.matrix_OE, 1);
      check("rst_mclk",  bus.matrix_clk, 0);
      check("rst_lat",   bus.matrix_lat, 0);
      check("rst_fd",    bus.frame_done, 0);
      check("rst_busy",  bus.busy, 0);
      check("rst_col",   bus.pix_column, 0);
      check("rst_row",   bus.pix_row, 0);
      check("rst_plane", bus.pix_plane, 0);
      check("rst_addr",  bus.matrix_addr, 0);
      check("rst_state", bus.dbg_state, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic do_ticks(input int n, input int drop_at, input bit toggle);
    int t;
    int cyc;
    bit ce;
    t = 0; cyc = 0; ce = 1'b0;
    prev = dut_vec();
    chk_on = 1'b1;
    while (t < n && cyc < 4 * n + 10) begin
      @(negedge clk);
      ce = toggle ? ~ce : 1'b1;
      if (t == drop_at) bus.enable = 1'b0;
      bus.clk_enable = ce;
      @(posedge clk);
      if (ce) t++;
      cyc++;
    end
    #2;
    chk_on = 1'b0;
    bus.clk_enable = 1'b0;
    check("tick_budget", t, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int start5;
    int exp_lat[5];
    int exp_runs[5];
    exp_lat  = '{0, 1, 2, 3, 0};
    exp_runs = '{4, 8, 4, 8, 4};
    bus.clk_enable = 1'b0;
    bus.enable = 1'b0;
    fd_count = 0; fd_idx = -1; oe_run = 0; clk_hi = 0;

    // Full frame, one extra pass with enable dropped in SHIFT_HI of column 1.
    do_reset(1'b1);
    model_reset();
    repeat (4) gen_pass();
    check("model_frame_len", exp_q.size(), 52);
    start5 = exp_q.size();
    gen_pass();
    gen_idle(8);
    lat_log.delete(); oe_runs.delete();
    fd_count = 0; fd_idx = -1; oe_run = 0; clk_hi = 0;
    bus.enable = 1'b1;
    do_ticks(exp_q.size(), start5 + 4, 1'b0);
    check("frame_queue_left", exp_q.size(), 0);
    check("latch_count", lat_log.size(), 5);
    for (int i = 0; i < 5 && i < lat_log.size(); i++)
      check($sformatf("latch_order_%0d", i), lat_log[i], exp_lat[i]);
    check("frame_done_count", fd_count, 1);
    check("frame_done_at_latch", fd_idx, 3);
    check("clk_rises", clk_hi, 20);
    check("oe_low_runs", oe_runs.size(), 5);
    for (int i = 0; i < 5 && i < oe_runs.size(); i++)
      check($sformatf("oe_low_run_%0d", i), oe_runs[i], exp_runs[i]);
    check("idle_oe", bus.matrix_OE, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_state", bus.dbg_state, ST_IDLE);

    // clk_enable toggling every cycle: same sequence, stretched.
    do_reset(1'b0);
    model_reset();
    gen_pass();
    gen_pass();
    bus.enable = 1'b1;
    do_ticks(exp_q.size(), -1, 1'b1);
    check("toggle_queue_left", exp_q.size(), 0);

    // Reset asserted during the plane-1 latch of row 0.
    do_reset(1'b0);
    model_reset();
    gen_pass();
    gen_pass();
    void'(exp_q.pop_back());
    bus.enable = 1'b1;
    do_ticks(exp_q.size(), -1, 1'b0);
    check("pre_rst_lat", bus.matrix_lat, 1);
    check("pre_rst_plane", bus.pix_plane, 1);
    check("pre_rst_col", bus.pix_column, 3);
    rst = 1'b1;
    #1;
    check("async_rst_oe", bus.matrix_OE, 1);
    check("async_rst_lat", bus.matrix_lat, 0);
    check("async_rst_col", bus.pix_column, 0);
    check("async_rst_row", bus.pix_row, 0);
    check("async_rst_plane", bus.pix_plane, 0);
    check("async_rst_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
